// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the shared-adder arbiter.
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_N       = 8;
   localparam int DEF_NUM_REQ = 4;
   localparam int CNT_W       = 16;

endpackage

// File: rtl/RippleCarry_Adder.sv
// Unsigned N-bit ripple-carry adder; the carry-out lands in result[N].
module RippleCarry_Adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] num1,
   input  logic [N-1:0] num2,
   output logic [N:0]   result
);

   logic [N:0] carry;

   assign carry[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_fa
         assign result[i]  = num1[i] ^ num2[i] ^ carry[i];
         assign carry[i+1] = (num1[i] & num2[i]) | (carry[i] & (num1[i] ^ num2[i]));
      end
   endgenerate

   assign result[N] = carry[N];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters.
// Optional per-requester grant counters are built when ADDER_ARB_STATS_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. req_ready is only offered in IDLE and never depends on req_valid of other
// requesters beyond the round-robin search; resp_valid, once high, holds with its
// data stable until resp_ready is seen high at an edge.
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*N-1:0] req_num1,
   input  logic [NUM_REQ*N-1:0] req_num2,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [N:0]           resp_result,
   output logic                 busy,
`ifdef ADDER_ARB_STATS_EN
   output logic [NUM_REQ*CNT_W-1:0] grant_count,
`endif
   output logic [1:0]           dbg_state
);

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [N-1:0]   op1;
   logic [N-1:0]   op2;
   logic [N:0]     sum;
   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   int             cand;

   RippleCarry_Adder #(.N(N)) u_adder (
      .num1   (op1),
      .num2   (op2),
      .result (sum)
   );

   // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_found && req_valid[cand[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_id     <= '0;
         op1         <= '0;
         op2         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  op1     <= req_num1[int'(grant_idx)*N +: N];
                  op2     <= req_num2[int'(grant_idx)*N +: N];
                  resp_id <= grant_idx;
                  state   <= CALC;
               end
            end
            CALC: begin
               resp_result <= sum;
               resp_valid  <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  rr_ptr     <= (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_ARB_STATS_EN
   logic [CNT_W-1:0] cnt [NUM_REQ];

   // Counters saturate rather than wrap so a long run never reports a small count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && cnt[i] != {CNT_W{1'b1}}) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      grant_count = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_count[i*CNT_W +: CNT_W] = cnt[i];
   end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a scoreboard queue of {id, sum}.
module tb_adder_share_arbiter;
   import adder_arb_pkg::*;

   localparam int N   = 8;
   localparam int NR  = 4;
   localparam int IDW = 2;
   localparam int W   = IDW + N + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*N-1:0] req_num1;
   logic [NR*N-1:0] req_num2;
   logic            resp_valid;
   logic            resp_ready;
   logic [IDW-1:0]  resp_id;
   logic [N:0]      resp_result;
   logic            busy;
   logic [1:0]      dbg_state;
`ifdef ADDER_ARB_STATS_EN
   logic [NR*16-1:0] grant_count;
`endif

   logic [N-1:0]   n1 [NR];
   logic [N-1:0]   n2 [NR];
   logic [W-1:0]   exp_q [$];
   logic [W-1:0]   last_exp;
   int             n_checks = 0;
   int             n_errors = 0;
   int             cyc = 0;

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_num1 = '0;
      req_num2 = '0;
      for (int i = 0; i < NR; i++) begin
         req_num1[i*N +: N] = n1[i];
         req_num2[i*N +: N] = n2[i];
      end
   end

   adder_share_arbiter #(.N(N), .NUM_REQ(NR)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_num1    (req_num1),
      .req_num2    (req_num2),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .busy        (busy),
`ifdef ADDER_ARB_STATS_EN
      .grant_count (grant_count),
`endif
      .dbg_state   (dbg_state)
   );

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle with inputs driven; expects requester g to win.
   task automatic issue(input int g);
      logic [W-1:0] e;
      #1;
      chk("grant_onehot", 32'(req_ready), 32'(1 << g));
      chk("busy_idle", 32'(busy), 32'd0);
      e = {IDW'(g), (N+1)'({1'b0, n1[g]} + {1'b0, n2[g]})};
      exp_q.push_back(e);
      step();
      chk("state_calc", 32'(dbg_state), 32'(CALC));
      chk("ready_calc", 32'(req_ready), 32'd0);
   endtask

   // scoreboard: wait (bounded) for the response and compare against the queue head
   task automatic collect(input string tag);
      int lat;
      lat = 1;
      while (!resp_valid && lat < 6) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd2);
      chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
      chk({tag, "_resp"}, 32'({resp_id, resp_result}), 32'(last_exp));
   endtask

   initial begin
      int t_prev;
      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         n1[i] = '0;
         n2[i] = '0;
      end
      step();
      step();

      // reset state, with a request pending that must not be acknowledged
      req_valid = 4'b0001;
      n1[0] = 8'h0F;
      n2[0] = 8'hF0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_result", 32'(resp_result), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef ADDER_ARB_STATS_EN
      chk("rst_counts_lo", grant_count[31:0], 32'd0);
      chk("rst_counts_hi", grant_count[63:32], 32'd0);
`endif
      step();
      rst = 1'b0;

      // single request; operands and valid change after the handshake
      issue(0);
      req_valid = '0;
      n1[0] = 8'h55;
      n2[0] = 8'h33;
      collect("single");
      chk("single_sum", 32'(resp_result), 32'h0FF);
      step();
      chk("single_done_valid", 32'(resp_valid), 32'd0);
      chk("single_done_busy", 32'(busy), 32'd0);

      // carry-out on requester 2
      req_valid = 4'b0100;
      n1[2] = 8'hFF;
      n2[2] = 8'hFF;
      issue(2);
      req_valid = '0;
      collect("carry");
      chk("carry_sum", 32'(resp_result), 32'h1FE);
      chk("carry_id", 32'(resp_id), 32'd2);
      step();

      // backpressure on requester 3 while everyone else is asking
      req_valid = 4'b1000;
      n1[3] = 8'h80;
      n2[3] = 8'h81;
      resp_ready = 1'b0;
      issue(3);
      req_valid = 4'b1111;
      collect("bp");
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_hold", 32'({resp_id, resp_result}), 32'(last_exp));
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      req_valid = 4'b0010;
      resp_ready = 1'b1;
      step();
      chk("bp_release_valid", 32'(resp_valid), 32'd0);
      chk("bp_release_state", 32'(dbg_state), 32'(IDLE));

      // reset in CALC discards the operation and clears rr_ptr
      n1[1] = 8'h12;
      n2[1] = 8'h34;
      issue(1);
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      void'(exp_q.pop_front());
      chk("midrst_state", 32'(dbg_state), 32'(IDLE));
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst_no_resp", 32'(resp_valid), 32'd0);
      end

      // round robin with all requesters asking: 0,1,2,3,0 every 3 cycles
      req_valid = 4'b1111;
      t_prev = -1;
      for (int i = 0; i < 5; i++) begin
         for (int r = 0; r < NR; r++) begin
            n1[r] = N'($urandom_range(0, 255));
            n2[r] = N'($urandom_range(0, 255));
         end
         if (t_prev >= 0) chk("rr_interval", 32'(cyc - t_prev), 32'd3);
         t_prev = cyc;
         issue(i % NR);
         collect("rr");
         step();
      end
      req_valid = '0;

`ifdef ADDER_ARB_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("stats_cleared", grant_count[31:0], 32'd0);
      req_valid = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         n1[1] = N'($urandom_range(0, 255));
         n2[1] = N'($urandom_range(0, 255));
         issue(1);
         collect("stats");
         step();
      end
      req_valid = '0;
      for (int i = 0; i < NR; i++)
         chk("stats_count", 32'(grant_count[i*16 +: 16]), (i == 1) ? 32'd3 : 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001: The module SHALL have parameter N, default 8, meaning the operand width in bits.
REQ-002: The module SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one adder, legal range 1..8.
REQ-003: Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004: Port rst, input, 1, is the reset, synchronous and active-high.
REQ-005: Port req_valid, input, NUM_REQ, is the per-requester operand-valid flag.
REQ-006: Port req_ready, output, NUM_REQ, is the per-requester accept strobe; at most one bit is high.
REQ-007: Port req_num1, input, NUM_REQ*N, carries requester i's first operand in bits [i*N +: N].
REQ-008: Port req_num2, input, NUM_REQ*N, carries requester i's second operand in bits [i*N +: N].
REQ-009: Port resp_valid, output, 1, flags that a result is presented.
REQ-010: Port resp_ready, input, 1, is the consumer's acceptance of the result.
REQ-011: Port resp_id, output, max(1,$clog2(NUM_REQ)), is the index of the requester owning the result.
REQ-012: Port resp_result, output, N+1, is the unsigned sum, with the carry-out in bit N.
REQ-013: Port busy, output, 1, is high whenever the state is not IDLE.

Function
REQ-014: The block SHALL use a three-state FSM: IDLE, CALC and DONE.
REQ-015: In IDLE, when any req_valid bit is high, the grant g SHALL be the first requester with req_valid high, searching from rr_ptr upward with wrap from NUM_REQ-1 to 0.
REQ-016: In the IDLE cycle with a valid request, req_ready[g] SHALL be asserted combinationally; that cycle is the handshake.
REQ-017: On that edge the block SHALL latch num1, num2 and g, and SHALL move to CALC.
REQ-018: req_ready SHALL be all-zero in CALC and DONE; requests arriving then wait.
REQ-019: In CALC, the latched operands feed the adder, and the adder output SHALL be registered into resp_result on the next edge; the state then moves to DONE.
REQ-020: In DONE, resp_valid=1 and resp_result/resp_id SHALL be held stable until resp_ready=1.
REQ-021: On the DONE handshake the block SHALL set resp_valid to 0, set rr_ptr to (g+1) mod NUM_REQ, and return to IDLE.
REQ-022: Latency: a request accepted at edge T SHALL give resp_valid high after edge T+2; the best-case issue interval is 3 cycles.
REQ-023: Arithmetic SHALL be unsigned and SHALL not overflow: 255+255 at N=8 gives 9'h1FE.
REQ-024: Deasserting req_valid or changing operands after the handshake SHALL not affect the in-flight result.
REQ-025: With NUM_REQ=1, rr_ptr SHALL stay 0 and requester 0 SHALL always win.

Reset
REQ-026: When rst=1 at an edge: state=IDLE, rr_ptr=0, resp_valid=0, resp_result=0, resp_id=0, busy=0, and req_ready SHALL be all-zero during that cycle.
REQ-027: A reset in CALC or DONE SHALL discard the in-flight operation with no response emitted; reset SHALL take priority over all handshakes.

Configuration
REQ-028: The macro ADDER_ARB_STATS_EN SHALL control grant statistics.
REQ-029: With ADDER_ARB_STATS_EN defined, the block SHALL add output grant_count of width NUM_REQ*16; it holds per-requester counters that increment on each req_ready handshake, saturate at 16'hFFFF, and reset to 0.
REQ-030: Without ADDER_ARB_STATS_EN defined, the port and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031: Package adder_arb_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE), the default N, the default NUM_REQ and the counter width 16.
REQ-032: The adder SHALL be one instance of the team's RippleCarry_Adder, parameterised with N, with ports num1, num2 and result[N:0]; no other sub-module SHALL be used.

Verification
REQ-033: Single request: req_valid=4'b0001, num1=8'h0F, num2=8'hF0, resp_ready=1 -> req_ready=4'b0001 at T, then resp_valid=1, resp_id=0, resp_result=9'h0FF after T+2.
REQ-034: Carry: num1=num2=8'hFF on requester 2 -> resp_result=9'h1FE, resp_id=2.
REQ-035: Round-robin: all four req_valid held high -> grants in order 0,1,2,3,0, one every 3 cycles.
REQ-036: Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_result stay stable, req_ready stays 0, busy=1; the response completes on the cycle resp_ready rises.
REQ-037: Reset mid-operation: rst=1 in CALC -> next cycle state=IDLE, resp_valid=0, rr_ptr=0, and no response is emitted.
REQ-038: Stats (macro defined): 3 grants to requester 1 -> grant_count[31:16]=3 and all other counters 0.
